mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester ports and the shared memory port of mem_arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of a fetch and a data port onto one fixed-latency memory
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        last_data_q;
    logic        port_data_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        busy_q;

    logic        grant_valid_d;
    logic        grant_data_d;

    // Data wins a conflict unless it was the last port served; reset points at fetch.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_data_d  = 1'b0;
        bus.if_ready  = 1'b0;
        bus.d_ready   = 1'b0;
        if (rst && state_q == IDLE && (bus.if_req || bus.d_req)) begin
            grant_valid_d = 1'b1;
            grant_data_d  = bus.d_req && (!bus.if_req || !last_data_q);
            bus.if_ready  = !grant_data_d;
            bus.d_ready   = grant_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            last_data_q <= 1'b0;
            port_data_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        last_data_q <= grant_data_d;
                        port_data_q <= grant_data_d;
                        we_q        <= grant_data_d && bus.d_we;
                        addr_q      <= grant_data_d ? bus.d_addr : bus.if_addr;
                        wdata_q     <= (grant_data_d && bus.d_we) ? bus.d_wdata : 32'd0;
                        wstrb_q     <= (grant_data_d && bus.d_we) ? bus.d_wstrb : 4'd0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_data_d && bus.d_we;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        d_rvalid_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        cnt_q   <= 3'd1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // The cycle where cnt_q reaches LAT is exactly MEM_LAT cycles after mem_en.
                    if (cnt_q == LAT) begin
                        cnt_q <= 3'd0;
                        if (port_data_q) begin
                            d_rdata_q  <= bus.mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= bus.mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.busy      = busy_q;
endmodule
